// File: rtl/mem_dump_tx_pkg.sv
// rtl/mem_dump_tx_pkg.sv - shared constants and FSM encoding for the RAM dump transmitter
package mem_dump_tx_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_NEXT  = 3'd6
    } state_e;

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - bit-period counter, ticks on the last cycle of each BAUD_DIV window
module baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [11:0] cnt_q;
    logic [11:0] cnt_d;

    assign tick = (cnt_q == 12'(BAUD_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 12'd1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - streams a RAM address range out as 8N1 serial frames
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int                BAUD_DIV   = 434,
    parameter logic [ADDR_W-1:0] FIRST_ADDR = 4'h0,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = 4'hF
) (
    input  logic              SysClock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [DATA_W-1:0] MDO,
    output logic [ADDR_W-1:0] RAMadd,
    output logic              RAMrd,
    output logic              TxD,
    output logic              Busy,
    output logic              Done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [2:0]          bit_q, bit_d;
    logic                txd_q, txd_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                tick;
    logic                baud_clr;

    // Restart the bit period whenever the FSM moves, so every phase gets full BAUD_DIV cycles.
    assign baud_clr = (state_d != state_q);

    baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk (SysClock),
        .rst (Reset),
        .clr (baud_clr),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        abort_d = abort_q;

        // Abort together with Start in IDLE still counts, yielding a single frame.
        if (Abort && (state_q != S_IDLE || Start)) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    addr_d  = FIRST_ADDR;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                sh_d    = MDO;
                txd_d   = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (tick) begin
                    txd_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        txd_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR || abort_q || Abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    abort_d = 1'b0;
                end else begin
                    addr_d  = addr_q + 4'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SysClock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= FIRST_ADDR;
            sh_q    <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign RAMadd = addr_q;
    assign RAMrd  = (state_q == S_READ);
    assign TxD    = txd_q;
    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb/tb_mem_dump_tx.sv - randomized self-checking bench for mem_dump_tx
module tb_mem_dump_tx;

    typedef struct {
        logic       t;
        logic       r;
        logic       b;
        logic       d;
        logic [3:0] a;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    logic [2:0] rd_v, txd_v, busy_v, done_v;
    logic [3:0] add_a, add_b, add_c;
    logic [7:0] mdo_a, mdo_b, mdo_c;
    logic [7:0] ram_a [16];
    logic [7:0] ram_b [16];
    logic [7:0] ram_c [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mdo_a <= ram_a[add_a];
        mdo_b <= ram_b[add_b];
        mdo_c <= ram_c[add_c];
    end

    mem_dump_tx #(.BAUD_DIV(4), .FIRST_ADDR(4'h0), .LAST_ADDR(4'h0)) u_a (
        .SysClock(clk), .Reset(rst), .Start(start_v[0]), .Abort(abort_v[0]), .MDO(mdo_a),
        .RAMadd(add_a), .RAMrd(rd_v[0]), .TxD(txd_v[0]), .Busy(busy_v[0]), .Done(done_v[0]));

    mem_dump_tx #(.BAUD_DIV(2), .FIRST_ADDR(4'h0), .LAST_ADDR(4'hF)) u_b (
        .SysClock(clk), .Reset(rst), .Start(start_v[1]), .Abort(abort_v[1]), .MDO(mdo_b),
        .RAMadd(add_b), .RAMrd(rd_v[1]), .TxD(txd_v[1]), .Busy(busy_v[1]), .Done(done_v[1]));

    mem_dump_tx #(.BAUD_DIV(3), .FIRST_ADDR(4'hE), .LAST_ADDR(4'h1)) u_c (
        .SysClock(clk), .Reset(rst), .Start(start_v[2]), .Abort(abort_v[2]), .MDO(mdo_c),
        .RAMadd(add_c), .RAMrd(rd_v[2]), .TxD(txd_v[2]), .Busy(busy_v[2]), .Done(done_v[2]));

    function automatic logic [7:0] ram_rd(input int sel, input int a);
        case (sel)
            0:       return ram_a[a];
            1:       return ram_b[a];
            default: return ram_c[a];
        endcase
    endfunction

    function automatic logic [3:0] add_of(input int sel);
        case (sel)
            0:       return add_a;
            1:       return add_b;
            default: return add_c;
        endcase
    endfunction

    // abort_mode: 0 none, 1 pulse during data bit 3 of word abort_word, 2 together with Start
    task automatic run_dump(input int sel, input int baud, input int first, input int last,
                            input int abort_mode, input int abort_word, input int extra_start,
                            input string name);
        int   addrs[$];
        cyc_t exp_q[$];
        int   a;
        int   abort_cyc;
        int   rd_seen;
        int   word_len;
        logic [7:0] dat;
        cyc_t e;
        word_len = 10 * baud + 3;
        a = first;
        for (int w = 0; w < 16; w++) begin
            addrs.push_back(a);
            if (a == last || abort_mode == 2 || (abort_mode == 1 && w == abort_word)) break;
            a = (a + 1) % 16;
        end
        foreach (addrs[i]) begin
            dat = ram_rd(sel, addrs[i]);
            exp_q.push_back('{t: 1'b1, r: 1'b1, b: 1'b1, d: 1'b0, a: 4'(addrs[i])});
            exp_q.push_back('{t: 1'b1, r: 1'b0, b: 1'b1, d: 1'b0, a: 4'(addrs[i])});
            for (int k = 0; k < baud; k++)
                exp_q.push_back('{t: 1'b0, r: 1'b0, b: 1'b1, d: 1'b0, a: 4'(addrs[i])});
            for (int bt = 0; bt < 8; bt++)
                for (int k = 0; k < baud; k++)
                    exp_q.push_back('{t: dat[bt], r: 1'b0, b: 1'b1, d: 1'b0, a: 4'(addrs[i])});
            for (int k = 0; k < baud + 1; k++)
                exp_q.push_back('{t: 1'b1, r: 1'b0, b: 1'b1, d: 1'b0, a: 4'(addrs[i])});
        end
        exp_q.push_back('{t: 1'b1, r: 1'b0, b: 1'b0, d: 1'b1, a: 4'(addrs[addrs.size()-1])});
        exp_q.push_back('{t: 1'b1, r: 1'b0, b: 1'b0, d: 1'b0, a: 4'(addrs[addrs.size()-1])});
        abort_cyc = 1 + abort_word * word_len + 2 + 4 * baud + 1;
        rd_seen = 0;

        @(negedge clk);
        start_v[sel] = 1'b1;
        abort_v[sel] = (abort_mode == 2);
        @(negedge clk);
        start_v[sel] = 1'b0;
        abort_v[sel] = 1'b0;
        for (int n = 1; n <= exp_q.size(); n++) begin
            e = exp_q[n-1];
            if (rd_v[sel] === 1'b1) rd_seen++;
            checks += 4;
            if (txd_v[sel] !== e.t) begin
                errors++;
                $display("FAIL %s txd cyc %0d got %b exp %b", name, n, txd_v[sel], e.t);
            end
            if (rd_v[sel] !== e.r) begin
                errors++;
                $display("FAIL %s ramrd cyc %0d got %b exp %b", name, n, rd_v[sel], e.r);
            end
            if (busy_v[sel] !== e.b) begin
                errors++;
                $display("FAIL %s busy cyc %0d got %b exp %b", name, n, busy_v[sel], e.b);
            end
            if (done_v[sel] !== e.d) begin
                errors++;
                $display("FAIL %s done cyc %0d got %b exp %b", name, n, done_v[sel], e.d);
            end
            if (e.r) begin
                checks++;
                if (add_of(sel) !== e.a) begin
                    errors++;
                    $display("FAIL %s ramadd cyc %0d got %h exp %h", name, n, add_of(sel), e.a);
                end
            end
            abort_v[sel] = (abort_mode == 1 && n == abort_cyc);
            start_v[sel] = (n == extra_start);
            @(negedge clk);
        end
        abort_v[sel] = 1'b0;
        start_v[sel] = 1'b0;
        checks++;
        if (rd_seen != addrs.size()) begin
            errors++;
            $display("FAIL %s ramrd_count got %0d exp %0d", name, rd_seen, addrs.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (txd_v !== 3'b111) begin errors++; $display("FAIL reset_txd got %b exp 111", txd_v); end
        if (busy_v !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", busy_v); end
        if (done_v !== 3'b000) begin errors++; $display("FAIL reset_done got %b exp 000", done_v); end
        if (rd_v !== 3'b000) begin errors++; $display("FAIL reset_ramrd got %b exp 000", rd_v); end
        if ({add_a, add_b, add_c} !== 12'h00E) begin
            errors++;
            $display("FAIL reset_ramadd got %h exp 00e", {add_a, add_b, add_c});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        foreach (ram_a[i]) ram_a[i] = 8'($urandom);
        ram_a[0] = 8'h3A;
        run_dump(0, 4, 0, 0, 0, 0, -1, "single_frame");
    endtask

    task automatic test_full_dump();
        foreach (ram_b[i]) ram_b[i] = 8'(i * 8'h11);
        abort_v[1] = 1'b1;
        @(negedge clk);
        abort_v[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort busy got %b exp 0", busy_v[1]);
        end
        run_dump(1, 2, 0, 15, 0, 0, -1, "full_dump");
    endtask

    task automatic test_abort();
        foreach (ram_b[i]) ram_b[i] = 8'($urandom);
        run_dump(1, 2, 0, 15, 1, 1, -1, "abort_frame2");
        run_dump(1, 2, 0, 15, 1, int'($urandom_range(0, 14)), -1, "abort_random");
        run_dump(1, 2, 0, 15, 2, 0, -1, "start_with_abort");
    endtask

    task automatic test_restart_ignored();
        foreach (ram_b[i]) ram_b[i] = 8'($urandom);
        run_dump(1, 2, 0, 15, 0, 0, int'($urandom_range(5, 300)), "restart_ignored");
    endtask

    task automatic test_wrap();
        foreach (ram_c[i]) ram_c[i] = 8'($urandom);
        run_dump(2, 3, 14, 1, 0, 0, -1, "wrap_e_to_1");
    endtask

    task automatic test_reset_mid_frame();
        logic saw_done;
        foreach (ram_b[i]) ram_b[i] = 8'($urandom);
        @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (txd_v[1] !== 1'b1) begin errors++; $display("FAIL midreset_txd got %b exp 1", txd_v[1]); end
        if (busy_v[1] !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy_v[1]); end
        if (add_b !== 4'h0) begin errors++; $display("FAIL midreset_ramadd got %h exp 0", add_b); end
        if (done_v[1] !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", done_v[1]); end
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_v[1] === 1'b1 || busy_v[1] === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet got %b exp 0", saw_done);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        abort_v = '0;
        foreach (ram_a[i]) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
            ram_c[i] = '0;
        end
        test_reset();
        test_single_frame();
        test_full_dump();
        test_abort();
        test_restart_ignored();
        test_wrap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 434, meaning SysClock cycles per serial bit (range 2..4095).
REQ-002 The block SHALL have parameter FIRST_ADDR, default 4'h0, meaning the first RAM address dumped.
REQ-003 The block SHALL have parameter LAST_ADDR, default 4'hF, meaning the last RAM address dumped.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port SysClock, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port Start, input, 1 bit: single-cycle request to begin a dump.
REQ-008 The block SHALL have port Abort, input, 1 bit: stop the dump after the current frame completes.
REQ-009 The block SHALL have port MDO, input, 8 bits: RAM read data, valid one cycle after the address is registered.
REQ-010 The block SHALL have port RAMadd, output, 4 bits: RAM read address.
REQ-011 The block SHALL have port RAMrd, output, 1 bit: RAM read strobe.
REQ-012 The block SHALL have port TxD, output, 1 bit: serial data line, idle high.
REQ-013 The block SHALL have port Busy, output, 1 bit: high while a dump is in progress.
REQ-014 The block SHALL have port Done, output, 1 bit: one-cycle pulse when a dump ends.

Function
REQ-015 The FSM SHALL have states IDLE, READ, WAIT, START, DATA, STOP, NEXT.
REQ-016 In IDLE, Start=1 SHALL load RAMadd=FIRST_ADDR and move the FSM to READ; Busy SHALL rise on the same edge.
REQ-017 READ SHALL last exactly 1 cycle with RAMrd=1, then go to WAIT; RAMrd SHALL be 0 in every other state.
REQ-018 WAIT SHALL last 1 cycle, then capture MDO into an 8-bit shift register and go to START.
REQ-019 START SHALL drive TxD=0 for BAUD_DIV cycles.
REQ-020 DATA SHALL drive 8 bits LSB-first, BAUD_DIV cycles each, using a 3-bit bit counter.
REQ-021 STOP SHALL drive TxD=1 for BAUD_DIV cycles, then go to NEXT.
REQ-022 In NEXT, if RAMadd==LAST_ADDR or an abort is latched, the FSM SHALL go to IDLE, pulse Done for 1 cycle, and drop Busy on the same edge.
REQ-023 Otherwise, in NEXT, RAMadd SHALL increment by 1 (4-bit, wrapping F->0) and the FSM SHALL go to READ.
REQ-024 If FIRST_ADDR > LAST_ADDR, the address SHALL wrap through F->0 until it reaches LAST_ADDR.
REQ-025 If FIRST_ADDR == LAST_ADDR, exactly one frame SHALL be sent.
REQ-026 The baud counter SHALL count from 0 to BAUD_DIV-1 and reset on every state change.
REQ-027 Frame period SHALL be 10*BAUD_DIV cycles; per-word cost SHALL be 10*BAUD_DIV+3 cycles.
REQ-028 Start while Busy SHALL be ignored; no restart and no queued request.
REQ-029 Abort while Busy SHALL be latched; the current frame SHALL finish intact and Done SHALL still pulse.
REQ-030 Abort in IDLE SHALL be ignored.
REQ-031 Start and Abort asserted in the same IDLE cycle SHALL start a dump of exactly one frame.
REQ-032 TxD SHALL never glitch between bits; it SHALL be driven from a register.

Reset
REQ-033 On the first SysClock edge with Reset=1, the block SHALL enter IDLE with TxD=1, Busy=0, Done=0, RAMrd=0, RAMadd=FIRST_ADDR, all counters cleared, and the abort latch cleared.
REQ-034 Reset SHALL override Start and Abort, and SHALL cut a frame mid-bit, forcing TxD=1 on that edge.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (3-bit), the frame length constant 10, and the RAM width constants ADDR_W=4 and DATA_W=8.
REQ-036 A natural sub-module SHALL be baud_tick, a parameterised BAUD_DIV counter with clear input and tick output; the shift register and FSM SHALL stay in mem_dump_tx.

Verification
REQ-037 With BAUD_DIV=4, FIRST=LAST=0, and RAM[0]=8'h3A, a Start pulse -> TxD SHALL be 0 (start bit), then 0,1,0,1,1,1,0,0, then 1 (stop), each held 4 cycles; Done SHALL pulse at cycle 44 after Start; Busy SHALL be high for cycles 1-43.
REQ-038 With BAUD_DIV=2 and a full dump 0..F with RAM[i]=i*8'h11 -> the bench SHALL see 16 frames 00,11,..,FF in order, RAMrd asserted exactly 16 times, and a single Done pulse.
REQ-039 Abort asserted during bit 3 of frame 2 (address 1) -> frame 2 SHALL complete, no further RAMrd SHALL occur, Done SHALL pulse, and Busy SHALL fall.
REQ-040 Start re-pulsed mid-dump -> the address sequence and TxD SHALL be unchanged from the run without the extra pulse.
REQ-041 Reset asserted during DATA bit 5 -> the next cycle SHALL show TxD=1, Busy=0, RAMadd=FIRST_ADDR, and no Done pulse.
REQ-042 With FIRST=E and LAST=1 -> addresses SHALL be E,F,0,1 and exactly 4 frames SHALL be sent.
